// File: rtl/seq_mod_reduce_p25519_if.sv
// Handshake/data bundle between the upstream multiplier, the p25519 reducer
// and its consumer.
interface seq_mod_reduce_p25519_if #(
  parameter int unsigned B  = 256,
  parameter int unsigned B2 = 512
);
  logic          start;
  logic [B2-1:0] product_in;
  logic [B-1:0]  result;
  logic          busy;
  logic          done;

  modport master (
    output start,
    output product_in,
    input  result,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  product_in,
    output result,
    output busy,
    output done
  );
endinterface

// File: rtl/seq_mod_reduce_p25519.sv
// Fixed-latency reducer: folds a 512-bit product mod 2^255-19 using
// 2^255 == 19, then applies one conditional subtract of q.
module seq_mod_reduce_p25519 #(
  parameter int unsigned B     = 256,
  parameter int unsigned B2    = 512,
  parameter int unsigned FOLDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  seq_mod_reduce_p25519_if.slave s_bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FOLD = 2'd1;
  localparam logic [1:0] S_SUB  = 2'd2;

  localparam int unsigned   CW       = (FOLDS > 1) ? $clog2(FOLDS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FOLDS - 1);
  localparam logic [B-1:0]  Q        = {1'b0, {(B-1){1'b1}}} - B'(18);

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [B2-1:0] r_acc;
  logic [B-1:0]  r_result;
  logic          r_busy;
  logic          r_done;

  logic [B2-1:0] w_lo;
  logic [B2-1:0] w_hi;
  logic [B2-1:0] w_fold;
  logic [B-1:0]  w_acc_lo;
  logic [B-1:0]  w_diff;
  logic          w_ge_q;

  // lo + 19*hi, with 19*hi built as hi*16 + hi*2 + hi; cannot overflow B2 bits
  always_comb begin
    w_lo     = {{(B2-B+1){1'b0}}, r_acc[B-2:0]};
    w_hi     = {{(B-1){1'b0}}, r_acc[B2-1:B-1]};
    w_fold   = w_lo + (w_hi << 4) + (w_hi << 1) + w_hi;
    w_acc_lo = r_acc[B-1:0];
    w_ge_q   = (r_acc[B2-1:B] != '0) || (w_acc_lo >= Q);
    w_diff   = w_acc_lo - Q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (s_bus.start) begin
            r_acc   <= s_bus.product_in;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_FOLD;
          end
        end
        S_FOLD: begin
          r_acc <= w_fold;
          if (r_cnt == CNT_LAST) begin
            r_state <= S_SUB;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_SUB: begin
          r_result <= w_ge_q ? w_diff : w_acc_lo;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign s_bus.result = r_result;
  assign s_bus.busy   = r_busy;
  assign s_bus.done   = r_done;

endmodule

// File: tb/tb_seq_mod_reduce_p25519.sv
// Directed bench for seq_mod_reduce_p25519 with hand-derived residues mod 2^255-19.
module tb_seq_mod_reduce_p25519;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  logic [255:0] q;
  logic [511:0] v_in [5];
  logic [255:0] v_exp [5];

  seq_mod_reduce_p25519_if #(.B(256), .B2(512)) bus ();

  seq_mod_reduce_p25519 #(.B(256), .B2(512), .FOLDS(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .s_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic launch(input logic [511:0] v);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.product_in = v;
    @(negedge clk);
    bus.start      = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    bit found;
    found = 1'b0;
    lat   = 0;
    while (!found && lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.done === 1'b1) found = 1'b1;
    end
    if (!found) lat = -1;
  endtask

  task automatic test_reset;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.product_in = '0;
    #1;
    n_total++;
    if ({bus.busy, bus.done} !== 2'b00) $display("FAIL reset_flags busy/done=%b required 00", {bus.busy, bus.done});
    else n_pass++;
    n_total++;
    if (bus.result !== 256'd0) $display("FAIL reset_result got %0h required 0", bus.result);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_zero;
    int lat;
    launch(512'd0);
    n_total++;
    if (bus.busy !== 1'b1) $display("FAIL zero_busy got %b required 1", bus.busy);
    else n_pass++;
    wait_done(lat);
    n_total++;
    if (lat !== 5) $display("FAIL zero_latency got %0d required 5", lat);
    else n_pass++;
    n_total++;
    if (bus.result !== 256'd0) $display("FAIL zero_result got %0h required 0", bus.result);
    else n_pass++;
    n_total++;
    if (bus.busy !== 1'b0) $display("FAIL zero_busy_at_done got %b required 0", bus.busy);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (bus.done !== 1'b0) $display("FAIL zero_done_width got %b required 0", bus.done);
    else n_pass++;
  endtask

  task automatic test_vectors;
    int lat;
    for (int i = 0; i < 5; i++) begin
      launch(v_in[i]);
      wait_done(lat);
      n_total++;
      if (lat !== 5) $display("FAIL vec%0d_latency got %0d required 5", i, lat);
      else n_pass++;
      n_total++;
      if (bus.result !== v_exp[i]) $display("FAIL vec%0d_result got %0h required %0h", i, bus.result, v_exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_ignored_start;
    int pulses;
    int first_idx;
    logic [255:0] first_res;
    pulses    = 0;
    first_idx = -1;
    first_res = '0;
    // accept at E0 with q+5, then try a second start one cycle later
    launch({256'd0, q} + 512'd5);
    bus.product_in = {128{4'hd}};
    @(negedge clk);
    n_total++;
    if (bus.busy !== 1'b1) $display("FAIL ignore_busy got %b required 1", bus.busy);
    else n_pass++;
    bus.start      = 1'b1;
    bus.product_in = 512'd54 << 255;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 3; k <= 14; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        pulses++;
        if (first_idx < 0) begin
          first_idx = k;
          first_res = bus.result;
        end
      end
    end
    n_total++;
    if (pulses !== 1) $display("FAIL ignore_pulses got %0d required 1", pulses);
    else n_pass++;
    n_total++;
    if (first_idx !== 5) $display("FAIL ignore_latency got %0d required 5", first_idx);
    else n_pass++;
    n_total++;
    if (first_res !== 256'd5) $display("FAIL ignore_result got %0h required 5", first_res);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int lat;
    int gap;
    launch(512'd54 << 255);
    wait_done(lat);
    n_total++;
    if (bus.result !== 256'd1026) $display("FAIL b2b_first_result got %0h required 402", bus.result);
    else n_pass++;
    bus.start      = 1'b1;
    bus.product_in = {256'd0, q} + 512'd7;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat);
    gap = (lat < 0) ? -1 : lat + 1;
    n_total++;
    if (gap !== 6) $display("FAIL b2b_interval got %0d required 6", gap);
    else n_pass++;
    n_total++;
    if (bus.result !== 256'd7) $display("FAIL b2b_second_result got %0h required 7", bus.result);
    else n_pass++;
  endtask

  task automatic test_mid_reset;
    int pulses;
    int lat;
    pulses = 0;
    launch(512'd54 << 255);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    n_total++;
    if ({bus.busy, bus.done} !== 2'b00) $display("FAIL midrst_flags busy/done=%b required 00", {bus.busy, bus.done});
    else n_pass++;
    n_total++;
    if (bus.result !== 256'd0) $display("FAIL midrst_result got %0h required 0", bus.result);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done === 1'b1) pulses++;
    end
    n_total++;
    if (pulses !== 0) $display("FAIL midrst_no_done got %0d required 0", pulses);
    else n_pass++;
    launch('1);
    wait_done(lat);
    n_total++;
    if (lat !== 5) $display("FAIL midrst_fresh_latency got %0d required 5", lat);
    else n_pass++;
    n_total++;
    if (bus.result !== 256'd1443) $display("FAIL midrst_fresh_result got %0h required 5a3", bus.result);
    else n_pass++;
  endtask

  initial begin
    logic [511:0] qm1;
    n_pass  = 0;
    n_total = 0;
    q = (256'd1 << 255) - 256'd19;
    qm1 = {256'd0, q} - 512'd1;
    v_in[0] = 512'd54 << 255;       v_exp[0] = 256'd1026;
    v_in[1] = {256'd0, q};          v_exp[1] = 256'd0;
    v_in[2] = {256'd0, q} + 512'd5; v_exp[2] = 256'd5;
    v_in[3] = (512'd1 << 255) - 1;  v_exp[3] = 256'd18;
    v_in[4] = qm1 * qm1;            v_exp[4] = 256'd1;

    test_reset;
    test_zero;
    test_vectors;
    test_ignored_start;
    test_back_to_back;
    test_mid_reset;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
